// File: rtl/tone_sequencer_pkg.sv
// Shared types, field widths and tune ROM contents for the tone sequencer.
// Each ROM entry is {note, dur}; dur = 0 marks the end of a tune.
package tone_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, PLAY, GAP} state_t;

    localparam int unsigned NOTE_W    = 5;
    localparam int unsigned DUR_W     = 5;
    localparam int unsigned SLOT_SIZE = 8;
    localparam int unsigned ROM_DEPTH = 32;
    localparam int unsigned ADDR_W    = $clog2(ROM_DEPTH);

    localparam logic [NOTE_W-1:0] NOTE_REST = 5'd0;

    typedef struct packed {
        logic [NOTE_W-1:0] note;
        logic [DUR_W-1:0]  dur;
    } entry_t;

    localparam entry_t TUNE_ROM [ROM_DEPTH] = '{
        {5'd6,  5'd2}, {5'd10, 5'd1}, {5'd13, 5'd3}, {5'd0, 5'd0},
        {5'd0,  5'd0}, {5'd0,  5'd0}, {5'd0,  5'd0}, {5'd0, 5'd0},
        {5'd15, 5'd1}, {5'd0,  5'd0}, {5'd0,  5'd0}, {5'd0, 5'd0},
        {5'd0,  5'd0}, {5'd0,  5'd0}, {5'd0,  5'd0}, {5'd0, 5'd0},
        {5'd1,  5'd1}, {5'd1,  5'd1}, {5'd1,  5'd1}, {5'd1, 5'd1},
        {5'd1,  5'd1}, {5'd1,  5'd1}, {5'd1,  5'd1}, {5'd1, 5'd1},
        {5'd0,  5'd0}, {5'd0,  5'd0}, {5'd0,  5'd0}, {5'd0, 5'd0},
        {5'd0,  5'd0}, {5'd0,  5'd0}, {5'd0,  5'd0}, {5'd0, 5'd0}
    };

endpackage

// File: rtl/tone_sequencer_if.sv
// Control-side handshake of the tone sequencer: requests in, note/status out.
interface tone_sequencer_if;

    logic       start;
    logic [1:0] tune_sel;
    logic       stop;
    logic [4:0] note;
    logic       busy;
    logic       done;

    modport master (output start, tune_sel, stop, input note, busy, done);
    modport slave  (input start, tune_sel, stop, output note, busy, done);

endinterface

// File: rtl/tone_sequencer_tune_rom.sv
// Synchronous-read 32x10 tune ROM, contents taken from the package.
module tune_rom
    import tone_pkg::*;
(
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output entry_t            data
);

    always_ff @(posedge clk) begin
        data <= TUNE_ROM[addr];
    end

endmodule

// File: rtl/tone_sequencer.sv
// Steps through a ROM tune, holding each note for dur ticks and inserting a
// silent gap between notes; sole driver of the tone generator's note code.
module tone_sequencer
    import tone_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 1_000_000,
    parameter int unsigned GAP_TICKS = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    tone_sequencer_if.slave   bus
);

    localparam int unsigned CW       = $clog2(31 * TICK_DIV + 1);
    localparam int unsigned SLOT_W   = $clog2(SLOT_SIZE) + 1;
    localparam int unsigned GAP_CYC  = GAP_TICKS * TICK_DIV;
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYC - 1);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [1:0]        tune_q, tune_nx;
    logic [SLOT_W-1:0] slot_q, slot_nx;
    entry_t            rom_q;
    logic              accept, abort, advance;

    assign abort   = bus.stop && (state != IDLE);
    assign accept  = bus.start && !bus.stop;
    assign advance = (cnt == '0) &&
                     ((state == GAP) || (state == PLAY && GAP_TICKS == 0));

    // ROM is addressed with the next index so its registered output always
    // matches the index held during FETCH.
    always_comb begin
        tune_nx = tune_q;
        slot_nx = slot_q;
        if (accept) begin
            tune_nx = bus.tune_sel;
            slot_nx = '0;
        end else if (!abort && advance) begin
            slot_nx = slot_q + 1'b1;
        end
    end

    tune_rom u_rom (
        .clk  (clk),
        .addr ({tune_nx, slot_nx[SLOT_W-2:0]}),
        .data (rom_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bus.note <= NOTE_REST;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            cnt      <= '0;
            tune_q   <= '0;
            slot_q   <= '0;
        end else begin
            tune_q   <= tune_nx;
            slot_q   <= slot_nx;
            bus.done <= 1'b0;
            if (abort) begin
                state    <= IDLE;
                bus.note <= NOTE_REST;
                bus.busy <= 1'b0;
            end else if (accept) begin
                state    <= FETCH;
                bus.note <= NOTE_REST;
                bus.busy <= 1'b1;
            end else begin
                unique case (state)
                    FETCH: begin
                        if (slot_q >= SLOT_W'(SLOT_SIZE) || rom_q.dur == '0) begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                        end else begin
                            state    <= PLAY;
                            bus.note <= rom_q.note;
                            cnt      <= CW'(32'(rom_q.dur) * TICK_DIV - 32'd1);
                        end
                    end
                    PLAY: begin
                        if (cnt == '0) begin
                            bus.note <= NOTE_REST;
                            if (GAP_TICKS == 0) begin
                                state <= FETCH;
                            end else begin
                                state <= GAP;
                                cnt   <= GAP_LOAD;
                            end
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    GAP: begin
                        if (cnt == '0) state <= FETCH;
                        else           cnt   <= cnt - 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
